// File: rtl/host_seq_pkg.sv
// Host memory sequencer shared definitions.
// Command/state encodings and memory geometry.
package host_seq_pkg;

   localparam int CMD_TYPE_W  = 3;
   localparam int CMD_ADDR_W  = 15;
   localparam int BUS_W       = 128;
   localparam int RD_W        = 8;

   localparam int ACT_W       = 8;
   localparam int PARAM_W     = 128;
   localparam int INST_W      = 80;

   localparam int ACT_AW      = 12;
   localparam int PARAM_AW    = 15;
   localparam int INST_AW     = 6;

   localparam int ACT_DEPTH   = 3000;
   localparam int PARAM_DEPTH = 25500;
   localparam int INST_DEPTH  = 64;

   localparam int RUN_TIMEOUT = 2**24 - 1;

   typedef enum logic [2:0] {
      CMD_LOAD_INST  = 3'd0,
      CMD_LOAD_PARAM = 3'd1,
      CMD_LOAD_ACT   = 3'd2,
      CMD_RUN        = 3'd3,
      CMD_READ_ACT   = 3'd4
   } cmd_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WRITE   = 3'd1,
      S_RUN     = 3'd2,
      S_RD_ADDR = 3'd3,
      S_RD_WAIT = 3'd4,
      S_RD_DATA = 3'd5
   } state_e;

   // Window [base, base+len) fits in depth; sum kept 16 bits wide.
   function automatic logic range_ok(
      input logic [CMD_ADDR_W-1:0] base,
      input logic [CMD_ADDR_W-1:0] len,
      input int                    depth
   );
      logic [15:0] sum;
      sum = {1'b0, base} + {1'b0, len};
      return sum <= 16'(depth);
   endfunction

endpackage

// File: rtl/host_mem_sequencer_if.sv
// Host-side command, write-stream and read-stream bundle.
// master = host, slave = sequencer.
interface host_mem_sequencer_if;
   import host_seq_pkg::*;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [CMD_TYPE_W-1:0] cmd_type;
   logic [CMD_ADDR_W-1:0] cmd_base;
   logic [CMD_ADDR_W-1:0] cmd_len;

   logic                  wr_valid;
   logic                  wr_ready;
   logic [BUS_W-1:0]      wr_data;

   logic                  rd_valid;
   logic                  rd_ready;
   logic [RD_W-1:0]       rd_data;

   modport master (
      output cmd_valid, cmd_type, cmd_base, cmd_len,
      output wr_valid, wr_data, rd_ready,
      input  cmd_ready, wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  cmd_valid, cmd_type, cmd_base, cmd_len,
      input  wr_valid, wr_data, rd_ready,
      output cmd_ready, wr_ready, rd_valid, rd_data
   );

endinterface

// File: rtl/seq_addr_cnt.sv
// Word address counter: load base, step, flag last word.
// last is high while the current word is the len-th one.
module seq_addr_cnt #(
   parameter int W = 15
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] base,
   input  logic [W-1:0] len,
   output logic [W-1:0] addr,
   output logic         last
);

   logic [W-1:0] cnt;
   logic [W-1:0] len_r;

   // Address and word index track each accepted word.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr  <= '0;
         cnt   <= '0;
         len_r <= '0;
      end else if (load) begin
         addr  <= base;
         cnt   <= '0;
         len_r <= len;
      end else if (inc) begin
         addr  <= addr + W'(1);
         cnt   <= cnt + W'(1);
      end
   end

   assign last = (cnt == len_r - W'(1));

endmodule

// File: rtl/host_mem_sequencer.sv
// Host memory sequencer: loads/reads core memories, runs core.
// Owns the external memory ports except while the core runs.
module host_mem_sequencer
   import host_seq_pkg::*;
#(
   parameter int WIDTH_ACT_MEM    = ACT_W,
   parameter int WIDTH_PARAM_MEM  = PARAM_W,
   parameter int WIDTH_INST_MEM   = INST_W,
   parameter int WIDTH_ADDR_ACT   = ACT_AW,
   parameter int WIDTH_ADDR_PARAM = PARAM_AW,
   parameter int WIDTH_ADDR_INST  = INST_AW,
   parameter int DEPTH_ACT_MEM    = ACT_DEPTH,
   parameter int DEPTH_PARAM_MEM  = PARAM_DEPTH,
   parameter int DEPTH_INST_MEM   = INST_DEPTH,
   parameter int TIMEOUT_CYCLES   = RUN_TIMEOUT
) (
   input  logic                        clk,
   input  logic                        resetn,
   host_mem_sequencer_if.slave         host,
   output logic                        sel_ext,
   output logic                        wea_instmem_ext,
   output logic                        wea_parammem_ext,
   output logic                        wea_actmem_ext,
   output logic [WIDTH_ADDR_INST-1:0]  addr_instmem_ext,
   output logic [WIDTH_ADDR_PARAM-1:0] addr_parammem_ext,
   output logic [WIDTH_ADDR_ACT-1:0]   addr_actmem_ext,
   output logic [WIDTH_INST_MEM-1:0]   instmem_in_ext,
   output logic [WIDTH_PARAM_MEM-1:0]  parammem_in_ext,
   output logic [WIDTH_ACT_MEM-1:0]    actmem_in_ext,
   input  logic [WIDTH_ACT_MEM-1:0]    actmem_out,
   output logic                        en,
   input  logic                        done,
   output logic                        busy,
   output logic                        cmd_done,
   output logic                        err
);

   localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT_CYCLES - 1);

   state_e                  state;
   state_e                  state_n;
   logic [CMD_TYPE_W-1:0]   tgt;
   logic [RUN_W-1:0]        run_cnt;
   logic [CMD_ADDR_W-1:0]   cnt_addr;
   logic                    cnt_last;
   logic                    cnt_load;
   logic                    cnt_inc;
   logic                    accept;
   logic                    legal;
   logic                    cmd_done_n;
   logic                    err_n;
   logic                    in_write;
   logic                    wr_hs;
   logic                    act_rd;
   logic                    sel_inst;
   logic                    sel_param;
   logic                    sel_act;

   seq_addr_cnt #(
      .W(CMD_ADDR_W)
   ) u_cnt (
      .clk    (clk),
      .resetn (resetn),
      .load   (cnt_load),
      .inc    (cnt_inc),
      .base   (host.cmd_base),
      .len    (host.cmd_len),
      .addr   (cnt_addr),
      .last   (cnt_last)
   );

   assign host.cmd_ready = (state == S_IDLE);
   assign host.wr_ready  = (state == S_WRITE);
   assign host.rd_valid  = (state == S_RD_DATA);
   assign busy           = (state != S_IDLE);
   assign sel_ext        = (state != S_RUN);
   assign en             = (state == S_RUN);
   assign accept         = host.cmd_valid && host.cmd_ready;

   // Command legality: known type and window inside target memory.
   always_comb begin
      legal = 1'b0;
      case (host.cmd_type)
         CMD_LOAD_INST:
            legal = range_ok(host.cmd_base, host.cmd_len, DEPTH_INST_MEM);
         CMD_LOAD_PARAM:
            legal = range_ok(host.cmd_base, host.cmd_len, DEPTH_PARAM_MEM);
         CMD_LOAD_ACT, CMD_READ_ACT:
            legal = range_ok(host.cmd_base, host.cmd_len, DEPTH_ACT_MEM);
         CMD_RUN:
            legal = 1'b1;
         default:
            legal = 1'b0;
      endcase
   end

   // Next-state, completion pulse, error and counter controls.
   always_comb begin
      state_n    = state;
      cmd_done_n = 1'b0;
      err_n      = err;
      cnt_load   = 1'b0;
      cnt_inc    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               if (!legal) begin
                  err_n      = 1'b1;
                  cmd_done_n = 1'b1;
               end else begin
                  err_n    = 1'b0;
                  cnt_load = 1'b1;
                  if (host.cmd_type == CMD_RUN) begin
                     state_n = S_RUN;
                  end else if (host.cmd_len == '0) begin
                     cmd_done_n = 1'b1;
                  end else if (host.cmd_type == CMD_READ_ACT) begin
                     state_n = S_RD_ADDR;
                  end else begin
                     state_n = S_WRITE;
                  end
               end
            end
         end
         S_WRITE: begin
            if (host.wr_valid) begin
               cnt_inc = 1'b1;
               if (cnt_last) begin
                  state_n    = S_IDLE;
                  cmd_done_n = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (done) begin
               state_n    = S_IDLE;
               cmd_done_n = 1'b1;
            end else if (run_cnt == RUN_LAST) begin
               state_n    = S_IDLE;
               cmd_done_n = 1'b1;
               err_n      = 1'b1;
            end
         end
         S_RD_ADDR: begin
            state_n = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            state_n = S_RD_DATA;
         end
         S_RD_DATA: begin
            if (host.rd_ready) begin
               if (cnt_last) begin
                  state_n    = S_IDLE;
                  cmd_done_n = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
                  state_n = S_RD_ADDR;
               end
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // State register; reset aborts any command in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Status flags, target latch and read data capture.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cmd_done     <= 1'b0;
         err          <= 1'b0;
         tgt          <= '0;
         host.rd_data <= '0;
      end else begin
         cmd_done <= cmd_done_n;
         err      <= err_n;
         if (accept) begin
            tgt <= host.cmd_type;
         end
         if (state == S_RD_WAIT) begin
            host.rd_data <= RD_W'(actmem_out);
         end
      end
   end

   // Watchdog on the core run, cleared whenever not running.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         run_cnt <= '0;
      end else if (state != S_RUN) begin
         run_cnt <= '0;
      end else begin
         run_cnt <= run_cnt + RUN_W'(1);
      end
   end

   assign in_write  = (state == S_WRITE);
   assign wr_hs     = in_write && host.wr_valid;
   assign act_rd    = (state == S_RD_ADDR) || (state == S_RD_WAIT)
                   || (state == S_RD_DATA);
   assign sel_inst  = (tgt == CMD_LOAD_INST);
   assign sel_param = (tgt == CMD_LOAD_PARAM);
   assign sel_act   = (tgt == CMD_LOAD_ACT);

   assign wea_instmem_ext  = wr_hs && sel_inst;
   assign wea_parammem_ext = wr_hs && sel_param;
   assign wea_actmem_ext   = wr_hs && sel_act;

   assign addr_instmem_ext  = (in_write && sel_inst)
                            ? cnt_addr[WIDTH_ADDR_INST-1:0] : '0;
   assign addr_parammem_ext = (in_write && sel_param)
                            ? cnt_addr[WIDTH_ADDR_PARAM-1:0] : '0;
   assign addr_actmem_ext   = ((in_write && sel_act) || act_rd)
                            ? cnt_addr[WIDTH_ADDR_ACT-1:0] : '0;

   assign instmem_in_ext  = (in_write && sel_inst)
                          ? host.wr_data[WIDTH_INST_MEM-1:0] : '0;
   assign parammem_in_ext = (in_write && sel_param)
                          ? host.wr_data[WIDTH_PARAM_MEM-1:0] : '0;
   assign actmem_in_ext   = (in_write && sel_act)
                          ? host.wr_data[WIDTH_ACT_MEM-1:0] : '0;

endmodule
